// File: rtl/text_screen_seq_pkg.sv
// Shared screen/state codes for the maze game text sequencer.
// Also used by the text overlay and the debug LED logic.
package text_screen_seq_pkg;

  typedef enum logic [2:0] {
    S_TITLE = 3'd0,
    S_RULES = 3'd1,
    S_GEN   = 3'd2,
    S_PLAY  = 3'd3,
    S_WIN   = 3'd4
  } state_t;

  localparam int STATE_W = 3;

endpackage

// File: rtl/text_screen_seq_frame_timer.sv
// Saturating frame counter with clear and a terminal-count hit on tick.
// The hit pulse is qualified by tick so callers act on frame edges only.
module text_screen_seq_frame_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             tick,
  input  logic [CNT_W-1:0] term,
  output logic             hit
);

  logic [CNT_W-1:0] cnt;

  assign hit = tick & (cnt == term);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (tick && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/text_screen_seq.sv
// Game phase sequencer: title, rules, maze generation, play, win.
// Overlay enables load only on frame_tick so text never tears.
module text_screen_seq
  import text_screen_seq_pkg::*;
#(
  parameter int BLINK_FRAMES = 30,
  parameter int RULES_FRAMES = 180,
  parameter int WIN_FRAMES   = 300,
  parameter int CNT_W        = 9
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start_btn,
  input  logic               maze_done,
  input  logic               at_exit,
  output logic               gen_start,
  output logic               play_en,
  output logic               title_on,
  output logic               press_start_on,
  output logic               rules_on,
  output logic               win_on,
  output logic [STATE_W-1:0] screen
);

  state_t           state;
  state_t           nxt;
  logic             start_q;
  logic             start_rise;
  logic             blink;
  logic [CNT_W-1:0] term;
  logic             hit;
  logic             cnt_clr;

  assign start_rise = start_btn & ~start_q;
  assign play_en    = (state == S_PLAY);
  assign screen     = state;

  always_comb begin
    term = '0;
    case (state)
      S_TITLE: term = CNT_W'(BLINK_FRAMES - 1);
      S_RULES: term = CNT_W'(RULES_FRAMES - 1);
      S_WIN:   term = CNT_W'(WIN_FRAMES - 1);
      default: term = '0;
    endcase
  end

  // One transition per cycle, decided from the current state only.
  always_comb begin
    nxt = state;
    case (state)
      S_TITLE: if (start_rise) nxt = S_RULES;
      S_RULES: if (start_rise || hit) nxt = S_GEN;
      S_GEN:   if (maze_done) nxt = S_PLAY;
      S_PLAY:  if (at_exit) nxt = S_WIN;
      S_WIN:   if (start_rise || hit) nxt = S_TITLE;
      default: nxt = S_TITLE;
    endcase
  end

  assign cnt_clr = (nxt != state) | ((state == S_TITLE) & hit);

  text_screen_seq_frame_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .tick (frame_tick),
    .term (term),
    .hit  (hit)
  );

  // start_q resets high so a button held through reset is not an edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_TITLE;
      start_q        <= 1'b1;
      blink          <= 1'b1;
      gen_start      <= 1'b0;
      title_on       <= 1'b0;
      press_start_on <= 1'b0;
      rules_on       <= 1'b0;
      win_on         <= 1'b0;
    end else begin
      start_q   <= start_btn;
      state     <= nxt;
      gen_start <= (state == S_RULES) && (nxt == S_GEN);
      if ((nxt == S_TITLE) && (state != S_TITLE)) begin
        blink <= 1'b1;
      end else if ((state == S_TITLE) && hit) begin
        blink <= ~blink;
      end
      if (frame_tick) begin
        title_on       <= (state == S_TITLE);
        press_start_on <= (state == S_TITLE) & blink;
        rules_on       <= (state == S_RULES);
        win_on         <= (state == S_WIN);
      end
    end
  end

endmodule

// File: tb/tb_text_screen_seq.sv
// Self-checking bench for text_screen_seq with short frame timings.
// Overlay expectations are queued per frame and checked by a monitor.
module tb_text_screen_seq;

  logic       clk;
  logic       reset;
  logic       frame_tick;
  logic       start_btn;
  logic       maze_done;
  logic       at_exit;
  logic       gen_start;
  logic       play_en;
  logic       title_on;
  logic       press_start_on;
  logic       rules_on;
  logic       win_on;
  logic [2:0] screen;

  int checks;
  int errors;
  int ph;
  logic [3:0] ovl_q[$];

  text_screen_seq #(
    .BLINK_FRAMES(2),
    .RULES_FRAMES(3),
    .WIN_FRAMES  (4),
    .CNT_W       (9)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .frame_tick    (frame_tick),
    .start_btn     (start_btn),
    .maze_done     (maze_done),
    .at_exit       (at_exit),
    .gen_start     (gen_start),
    .play_en       (play_en),
    .title_on      (title_on),
    .press_start_on(press_start_on),
    .rules_on      (rules_on),
    .win_on        (win_on),
    .screen        (screen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Overlay scoreboard: one queued expectation per checked frame tick.
  always begin
    @(posedge clk);
    if (reset && frame_tick && ovl_q.size() > 0) begin
      logic [3:0] e;
      e = ovl_q.pop_front();
      #1;
      chk("overlay", {4'h0, title_on, press_start_on, rules_on, win_on},
          {4'h0, e});
    end
  end

  task automatic clk1();
    @(negedge clk);
    ph = (ph == 9) ? 0 : ph + 1;
    frame_tick = (ph == 0);
  endtask

  task automatic to_tick();
    int n;
    n = 0;
    do begin
      clk1();
      n++;
    end while (!frame_tick && n < 12);
    if (!frame_tick) chk("tick_timeout", 8'd0, 8'd1);
  endtask

  task automatic tick(input logic [3:0] e);
    ovl_q.push_back(e);
    to_tick();
    clk1();
  endtask

  task automatic tick_nc();
    to_tick();
    clk1();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    ph = 0;
    reset = 1'b0;
    frame_tick = 1'b0;
    start_btn = 1'b0;
    maze_done = 1'b0;
    at_exit = 1'b0;
    repeat (3) clk1();
    chk("rst_outs", {1'b0, title_on, press_start_on, rules_on, win_on,
        gen_start, play_en, 1'b0}, 8'h00);
    chk("rst_screen", {5'd0, screen}, 8'd0);

    reset = 1'b1;
    tick(4'b1100);
    tick(4'b1100);
    tick(4'b1000);
    tick(4'b1000);
    tick(4'b1100);
    chk("title_screen", {5'd0, screen}, 8'd0);

    reset = 1'b0;
    start_btn = 1'b1;
    repeat (2) clk1();
    reset = 1'b1;
    repeat (3) clk1();
    chk("held_no_edge", {5'd0, screen}, 8'd0);
    start_btn = 1'b0;
    clk1();
    tick_nc();
    start_btn = 1'b1;
    clk1();
    chk("to_rules", {5'd0, screen}, 8'd1);
    start_btn = 1'b0;

    tick(4'b0010);
    tick(4'b0010);
    chk("rules_hold", {5'd0, screen}, 8'd1);
    ovl_q.push_back(4'b0010);
    to_tick();
    clk1();
    chk("gen_pulse", {7'd0, gen_start}, 8'd1);
    chk("to_gen", {5'd0, screen}, 8'd2);
    clk1();
    chk("gen_pulse_end", {7'd0, gen_start}, 8'd0);
    tick(4'b0000);

    at_exit = 1'b1;
    clk1();
    at_exit = 1'b0;
    chk("gen_ign_exit", {5'd0, screen}, 8'd2);
    start_btn = 1'b1;
    clk1();
    start_btn = 1'b0;
    clk1();
    chk("gen_ign_start", {5'd0, screen}, 8'd2);
    maze_done = 1'b1;
    clk1();
    maze_done = 1'b0;
    chk("to_play", {5'd0, screen}, 8'd3);
    chk("play_en_on", {7'd0, play_en}, 8'd1);
    at_exit = 1'b1;
    clk1();
    at_exit = 1'b0;
    chk("to_win", {5'd0, screen}, 8'd4);
    chk("play_en_off", {7'd0, play_en}, 8'd0);

    tick(4'b0001);
    tick(4'b0001);
    tick(4'b0001);
    ovl_q.push_back(4'b0001);
    to_tick();
    start_btn = 1'b1;
    clk1();
    chk("win_to_title", {5'd0, screen}, 8'd0);
    clk1();
    chk("single_trans", {5'd0, screen}, 8'd0);
    start_btn = 1'b0;
    tick(4'b1100);
    tick(4'b1100);
    tick(4'b1000);

    start_btn = 1'b1;
    clk1();
    start_btn = 1'b0;
    clk1();
    start_btn = 1'b1;
    clk1();
    chk("gen_pulse2", {7'd0, gen_start}, 8'd1);
    start_btn = 1'b0;
    maze_done = 1'b1;
    clk1();
    maze_done = 1'b0;
    chk("play2", {7'd0, play_en}, 8'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("async_outs", {1'b0, title_on, press_start_on, rules_on, win_on,
        gen_start, play_en, 1'b0}, 8'h00);
    chk("async_screen", {5'd0, screen}, 8'd0);
    clk1();
    reset = 1'b1;
    clk1();
    chk("queue_empty", 8'(ovl_q.size()), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/text_screen_seq.md
Name: text_screen_seq

Overview:
- Sequences the maze generator's text overlays and game phases: title, rules, maze generation, play and win.
- Drives the region enables consumed by the font text generator and the start pulse for the maze generator.
- Sits between the VGA sync/timing block (frame tick), the button debouncers, the maze generator and the text overlay.
- Enables change only on frame boundaries so text never tears mid-frame.

Parameters:
- BLINK_FRAMES, 30, frames per half-period of the "Press Start" blink.
- RULES_FRAMES, 180, frames the rules screen shows before auto-advancing.
- WIN_FRAMES, 300, frames the win screen shows before returning to title.
- CNT_W, 9, frame-counter width; must hold max(BLINK_FRAMES, RULES_FRAMES, WIN_FRAMES).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse at start of each frame (vertical blank).
- start_btn  in  1  debounced start button level.
- maze_done  in  1  one-cycle pulse: maze generation finished.
- at_exit  in  1  one-cycle pulse: player reached maze exit.
- gen_start  out  1  one-cycle pulse requesting maze generation.
- play_en  out  1  player movement enabled.
- title_on  out  1  overlay enable: "MAZE GENERATOR" title.
- press_start_on  out  1  overlay enable: "Press Start" (blinking).
- rules_on  out  1  overlay enable: rules text.
- win_on  out  1  overlay enable: win text.
- screen  out  3  current state code, for debug LEDs.

Behaviour:
- Reset is asynchronous, active-low. On reset: state TITLE, frame counter 0, blink phase 1, all outputs 0 except screen=TITLE. Overlay enables take effect from the first frame_tick after reset.
- Start edge detection: start_btn is registered once. start_rise = start_btn & ~start_btn_q. A button held through reset does not produce an edge.
- State codes: TITLE=0, RULES=1, GEN=2, PLAY=3, WIN=4. Codes 5-7 are illegal and recover to TITLE on the next clock.
- Frame counter: clears on every state transition. Otherwise it increments on frame_tick and saturates at 2^CNT_W-1.
- TITLE:
  - Blink phase toggles when frame_tick arrives with counter==BLINK_FRAMES-1; the counter clears at that point.
  - start_rise -> RULES.
- RULES:
  - start_rise, or frame_tick with counter==RULES_FRAMES-1 -> GEN.
  - gen_start pulses high for exactly the one cycle in which the state register becomes GEN.
- GEN: maze_done -> PLAY. start_rise is ignored. No timeout.
- PLAY:
  - play_en=1 combinationally from state, with no frame alignment.
  - at_exit -> WIN. play_en drops on the cycle after at_exit.
- WIN: start_rise, or frame_tick with counter==WIN_FRAMES-1 -> TITLE. Blink phase resets to 1 on entry to TITLE.
- Simultaneous events:
  - Transition conditions are evaluated on the current state only; one transition per cycle.
  - If start_rise and the timeout coincide in RULES or WIN, a single transition occurs.
  - maze_done while not in GEN and at_exit while not in PLAY are ignored.
- Overlay registers: title_on, press_start_on, rules_on and win_on load their state-decoded values only on frame_tick.
  - title_on = (state==TITLE).
  - press_start_on = (state==TITLE) & blink phase.
  - rules_on = (state==RULES).
  - win_on = (state==WIN).
  - Latency: the overlay follows a state change at the next frame_tick.
  - A frame_tick on the same cycle as a transition samples the pre-transition state.
- screen is registered and equals the current state code.

Decomposition:
- Shared package/include file holds the state codes, reused by the text overlay and debug logic.
- Sub-module frame_timer: frame counter with clear, tick and terminal-compare outputs, instantiated once.
- Edge detect and the FSM stay in the top level.

Test Plan (BLINK_FRAMES=2, RULES_FRAMES=3, WIN_FRAMES=4, frame_tick every 10 clocks):
- Reset release, no input:
  - title_on=1 after the first tick; press_start_on=1.
  - press_start_on toggles every 2 ticks: 1,1,0,0,1; screen=0.
- start_btn held high across reset deassertion: no transition; screen stays 0. Releasing and re-pressing gives RULES on the cycle after the rise.
- In RULES, no input: GEN entered at the 3rd frame_tick; gen_start high for exactly 1 cycle; rules_on clears at the next tick.
- In GEN: pulse at_exit, then start, then maze_done -> first two ignored; maze_done gives PLAY with play_en=1 the next cycle. Then at_exit -> WIN, play_en=0.
- In WIN: start_rise on the same cycle as the 4th tick -> exactly one transition to TITLE; win_on drops at the following tick; blink restarts at 1.
- Assert reset low mid-PLAY, asynchronously between clock edges -> play_en, gen_start and all enables 0 immediately; screen=0.
